// File: rtl/cond_exec_stage_if.sv
// Execute-to-memory bus for the conditional-execution stage: decode controls and ALU
// results go in, gated memory-stage controls and the condition flags come out.
interface cond_exec_stage_if #(
    parameter int DATA_W = 32
);
    // in_valid marks an instruction in execute. There is no ready: stall=1 makes the stage
    // hold everything, and upstream keeps the same instruction (and any flush) on the bus.
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [3:0]        Cond;
    logic [1:0]        FlagW;
    logic              PCS;
    logic              RegW;
    logic              MemW;
    logic [3:0]        ALUFlags;
    logic [DATA_W-1:0] ALUResult;
    logic [3:0]        WA3;

    logic              CondEx;
    logic [3:0]        Flags;
    logic              ValidM;
    logic              PCSrcM;
    logic              RegWriteM;
    logic              MemWriteM;
    logic [DATA_W-1:0] ALUResultM;
    logic [3:0]        WA3M;

    modport master (
        output in_valid, stall, flush, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ALUResult, WA3,
        input  CondEx, Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M
    );

    modport slave (
        input  in_valid, stall, flush, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ALUResult, WA3,
        output CondEx, Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M
    );
endinterface

// File: rtl/cond_exec_stage.sv
// ARM-style conditional execution: evaluates Cond against the stored NZCV flags, gates the
// decode controls, commits selected flag halves and registers the execute->memory stage.
module cond_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    cond_exec_stage_if.slave   bus
);
    logic [3:0]        flags_q;
    logic              valid_q;
    logic              pcsrc_q;
    logic              regwrite_q;
    logic              memwrite_q;
    logic [DATA_W-1:0] result_q;
    logic [3:0]        wa3_q;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;
    logic commit;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluated on the pre-update flags: an instruction never sees its own flag write.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign commit = bus.in_valid & cond_ex & ~bus.flush;

    // Stall wins over flush; a flush seen during a stall is dropped and re-driven upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= 4'b0000;
            valid_q    <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            result_q   <= '0;
            wa3_q      <= 4'b0000;
        end else if (!bus.stall) begin
            if (commit && bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (commit && bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
            valid_q    <= bus.in_valid & ~bus.flush;
            pcsrc_q    <= bus.PCS & commit;
            regwrite_q <= bus.RegW & commit;
            memwrite_q <= bus.MemW & commit;
            result_q   <= bus.ALUResult;
            wa3_q      <= bus.WA3;
        end
    end

    assign bus.CondEx     = cond_ex;
    assign bus.Flags      = flags_q;
    assign bus.ValidM     = valid_q;
    assign bus.PCSrcM     = pcsrc_q;
    assign bus.RegWriteM  = regwrite_q;
    assign bus.MemWriteM  = memwrite_q;
    assign bus.ALUResultM = result_q;
    assign bus.WA3M       = wa3_q;
endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed and random stimulus for cond_exec_stage, checked against an expected-output
// queue fed by an independent flag/condition model.
module tb_cond_exec_stage;
    localparam int DATA_W = 32;
    localparam int W      = 8 + DATA_W;   // {ValidM,PCSrcM,RegWriteM,MemWriteM,WA3M,ALUResultM}

    logic clk;
    logic reset;

    cond_exec_stage_if #(.DATA_W(DATA_W)) bus ();

    cond_exec_stage #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [3:0]   flags_q[$];
    int checks = 0;
    int errors = 0;

    logic [3:0]        m_flags;
    logic              m_valid, m_pcs, m_regw, m_memw;
    logic [DATA_W-1:0] m_result;
    logic [3:0]        m_wa3;

    // Condition model in base/invert form: Cond[3:1] selects a test, Cond[0] inverts it.
    function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n ~^ v);
            3'd6: base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: one clock per call; inputs set on the falling edge, outputs sampled 1 after rise
    task automatic drive(input string tag, input logic rst, input logic v, input logic st,
                         input logic fl, input logic [3:0] cond, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic [3:0] aluf, input logic [DATA_W-1:0] res,
                         input logic [3:0] wa3);
        logic pass, cm;
        logic [W-1:0] exp_o;
        logic [3:0]   exp_f;
        @(negedge clk);
        reset = rst; bus.in_valid = v; bus.stall = st; bus.flush = fl;
        bus.Cond = cond; bus.FlagW = fw; bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw;
        bus.ALUFlags = aluf; bus.ALUResult = res; bus.WA3 = wa3;
        #1;
        pass = model_cond(m_flags, cond);
        if (!rst) check({tag, "_condex"}, W'(bus.CondEx), W'(pass));
        if (rst) begin
            m_flags = 4'b0; m_valid = 0; m_pcs = 0; m_regw = 0; m_memw = 0;
            m_result = '0; m_wa3 = 4'b0;
        end else if (!st) begin
            cm = v && pass && !fl;
            if (cm && fw[1]) m_flags[3:2] = aluf[3:2];
            if (cm && fw[0]) m_flags[1:0] = aluf[1:0];
            m_valid = v && !fl;
            m_pcs = pcs && cm; m_regw = regw && cm; m_memw = memw && cm;
            m_result = res; m_wa3 = wa3;
        end
        exp_q.push_back({m_valid, m_pcs, m_regw, m_memw, m_wa3, m_result});
        flags_q.push_back(m_flags);
        @(posedge clk);
        #1;
        exp_o = exp_q.pop_front();
        exp_f = flags_q.pop_front();
        check({tag, "_mout"}, {bus.ValidM, bus.PCSrcM, bus.RegWriteM, bus.MemWriteM,
                               bus.WA3M, bus.ALUResultM}, exp_o);
        check({tag, "_flags"}, W'(bus.Flags), W'(exp_f));
    endtask

    // shorthand for an unstalled, unflushed valid instruction
    task automatic instr(input string tag, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] aluf, input logic regw);
        drive(tag, 0, 1, 0, 0, cond, fw, 1'b1, regw, 1'b1, aluf, $urandom, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        m_flags = 4'b0;
        reset = 1; bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.Cond = 0; bus.FlagW = 0;
        bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.ALUFlags = 0; bus.ALUResult = 0; bus.WA3 = 0;

        drive("reset0", 1, 1, 1, 1, 4'hE, 2'b11, 1, 1, 1, 4'hF, 32'hDEAD_BEEF, 4'h7);
        drive("reset1", 1, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 4'h0, 32'h0, 4'h0);

        // post-reset condition evaluation with no instruction present
        drive("rst_eq", 0, 0, 0, 0, 4'h0, 2'b11, 1, 1, 1, 4'hF, 32'h1111_0000, 4'h1);
        drive("rst_ne", 0, 0, 0, 0, 4'h1, 2'b11, 1, 1, 1, 4'hF, 32'h2222_0000, 4'h2);
        drive("rst_al", 0, 0, 0, 0, 4'hE, 2'b11, 1, 1, 1, 4'hF, 32'h3333_0000, 4'h3);

        instr("al_setz", 4'hE, 2'b11, 4'b0100, 1);
        instr("eq_pass", 4'h0, 2'b00, 4'b0000, 1);
        instr("ne_fail", 4'h1, 2'b00, 4'b0000, 1);

        // half-width flag write, then a consumer seeing the new flags
        instr("clr_flags", 4'hE, 2'b11, 4'b0000, 0);
        instr("nz_only",   4'hE, 2'b10, 4'b1011, 0);
        instr("lt_pass",   4'hB, 2'b00, 4'b0000, 1);

        // own flag write does not change own condition
        instr("set_z",     4'hE, 2'b11, 4'b0100, 0);
        instr("eq_wr_clr", 4'h0, 2'b11, 4'b0000, 1);
        instr("eq_after",  4'h0, 2'b00, 4'b0000, 1);

        // never condition does not pass or write flags
        instr("nv_nowr",   4'hF, 2'b11, 4'b1111, 1);

        // stall for three cycles, then release
        for (int i = 0; i < 3; i++)
            drive("stall", 0, 1, 1, 0, 4'hE, 2'b11, 1, 1, 1, 4'hF, 32'hCAFE_0000 + i, 4'h9);
        drive("stall_rel", 0, 1, 0, 0, 4'hE, 2'b11, 1, 1, 1, 4'hF, 32'hCAFE_00FF, 4'h9);

        // flush, and stall overriding flush
        drive("flush",     0, 1, 0, 1, 4'hE, 2'b11, 1, 1, 1, 4'h0, 32'hF00D_0001, 4'hA);
        drive("stall_fl",  0, 1, 1, 1, 4'hE, 2'b11, 1, 1, 1, 4'h0, 32'hF00D_0002, 4'hB);
        drive("refl",      0, 1, 0, 1, 4'hE, 2'b11, 1, 1, 1, 4'h0, 32'hF00D_0003, 4'hC);

        // every condition against every flag pattern
        for (int f = 0; f < 16; f++) begin
            instr("set_pat", 4'hE, 2'b11, 4'(f), 0);
            for (int c = 0; c < 16; c++)
                instr("cond_sweep", 4'(c), 2'b00, 4'h0, 1);
        end

        // random traffic including stalls and flushes
        for (int i = 0; i < 300; i++)
            drive("rand", 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));

        // mid-stream reset while stalled
        instr("pre_rst", 4'hE, 2'b11, 4'b1111, 1);
        drive("rst_mid", 1, 1, 1, 0, 4'hE, 2'b11, 1, 1, 1, 4'hF, 32'h5555_AAAA, 4'hD);
        drive("after_rst_ne", 0, 1, 0, 0, 4'h1, 2'b00, 1, 1, 1, 4'h0, 32'h0000_0042, 4'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, width of the ALU result path.
REQ-002 The block SHALL have a port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have a port in_valid, input, 1 bit: execute-stage instruction present.
REQ-005 The block SHALL have a port stall, input, 1 bit: hold all stage state.
REQ-006 The block SHALL have a port flush, input, 1 bit: kill the current execute-stage instruction.
REQ-007 The block SHALL have a port Cond, input, 4 bits: instruction condition field.
REQ-008 The block SHALL have a port FlagW, input, 2 bits: [1] writes N,Z; [0] writes C,V.
REQ-009 The block SHALL have ports PCS, RegW and MemW, inputs, 1 bit each: ungated control from decode.
REQ-010 The block SHALL have a port ALUFlags, input, 4 bits: {Negative, Zero, Carry, Overflow} from the ALU.
REQ-011 The block SHALL have a port ALUResult, input, DATA_W bits: ALU result.
REQ-012 The block SHALL have a port WA3, input, 4 bits: destination register index.
REQ-013 The block SHALL have a port CondEx, output, 1 bit: combinational condition-pass.
REQ-014 The block SHALL have a port Flags, output, 4 bits: registered {N,Z,C,V}.
REQ-015 The block SHALL have ports ValidM, PCSrcM, RegWriteM and MemWriteM, outputs, 1 bit each: registered, gated.
REQ-016 The block SHALL have a port ALUResultM, output, DATA_W bits: registered ALU result.
REQ-017 The block SHALL have a port WA3M, output, 4 bits: registered destination index.

Function
REQ-018 CondEx SHALL be computed combinationally from the Flags register (the pre-update flags) and Cond, per the following table.
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C & !Z
- 1001 LS: !C | Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z & (N==V)
- 1101 LE: Z | (N!=V)
- 1110 AL: 1
- 1111: 0
REQ-019 A stage advance SHALL be defined as rising edge with reset=0 and stall=0.
REQ-020 A flag commit SHALL be defined as advance & in_valid & CondEx & !flush.
REQ-021 On a flag commit, FlagW[1] SHALL load Flags[3:2] from ALUFlags[3:2] and FlagW[0] SHALL load Flags[1:0] from ALUFlags[1:0]; unselected halves SHALL hold.
REQ-022 An instruction's own flag write SHALL NOT affect its own CondEx; the next instruction SHALL see the new flags, giving 1-cycle flag latency with no bypass.
REQ-023 On advance, ValidM SHALL load in_valid & !flush.
REQ-024 On advance, PCSrcM, RegWriteM and MemWriteM SHALL load PCS, RegW and MemW respectively, each ANDed with in_valid & CondEx & !flush.
REQ-025 On advance, ALUResultM and WA3M SHALL load ALUResult and WA3 unconditionally, including for failed or flushed instructions.
REQ-026 Stage latency SHALL be 1 cycle from execute inputs to M outputs.
REQ-027 When stall=1 and flush=0, all registers including Flags SHALL hold.
REQ-028 stall=1 SHALL take priority over flush=1: all registers hold and the flush is dropped; upstream re-asserts flush when the stall releases.
REQ-029 When in_valid=0, the block SHALL perform no flag commit and SHALL load ValidM=0 and all gated controls=0 on advance.
REQ-030 Cond=1111 SHALL never pass and SHALL never write flags.

Reset
REQ-031 A rising edge with reset=1 SHALL clear Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM and WA3M to 0, overriding stall and flush.
REQ-032 After reset, CondEx SHALL reflect flags 0000: EQ fails, NE passes, AL passes.
REQ-033 A reset asserted mid-stream SHALL discard the in-flight instruction with no flag update.

Verification
REQ-034 After reset, apply Cond=1110, FlagW=11, ALUFlags=0100, RegW=1, in_valid=1 -> next cycle Flags=0100, RegWriteM=1, ValidM=1.
REQ-035 With Flags=0100, apply Cond=0000 then Cond=0001, each with RegW=1 -> RegWriteM is 1 then 0, and ValidM is 1 for both.
REQ-036 With Flags=0000 apply Cond=1110, FlagW=10, ALUFlags=1011, and next cycle apply Cond=1011 (LT) -> Flags=1000 (C,V held), and the second instruction passes since N=1 and V=0.
REQ-037 Hold stall=1 for 3 cycles with new inputs (FlagW=11, ALUFlags=1111) -> Flags and all M outputs unchanged, and after release they update on the first edge.
REQ-038 Apply flush=1 with in_valid=1, MemW=1, FlagW=11 -> ValidM=0, MemWriteM=0, Flags unchanged, ALUResultM still loaded.
REQ-039 Assert reset for one cycle mid-stream with stall=1 -> all outputs 0 and Flags=0000 on the next edge.
